// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with stall, flush, optional skid buffer and stall counter
// Ports: clk/reset (async, active-high); in_valid/in_ctrl/in_data/in_ready upstream beat;
//        stall/flush from hazard control; out_valid/out_ctrl/out_data registered beat;
//        stall_cycles saturating count of cycles the held beat was stalled.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cycles
);
  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;
  state_t             r_state, w_state_nx;
  logic               r_out_valid, w_valid_nx;
  logic [CTRL_W-1:0]  r_out_ctrl, w_ctrl_nx, r_skid_ctrl, w_skc_nx;
  logic [DATA_W-1:0]  r_out_data, w_data_nx, r_skid_data, w_skd_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_ld, w_acc;
  // With a skid buffer, ready comes straight from state so upstream never sees stall combinationally.
  assign in_ready     = (SKID != 0) ? (r_state != S_SKID) : ~stall;
  assign w_acc        = in_valid & in_ready;
  assign w_ld         = ~stall | ~r_out_valid;
  assign out_valid    = r_out_valid;
  assign out_ctrl     = r_out_ctrl;
  assign out_data     = r_out_data;
  assign stall_cycles = r_cnt;
  // EMPTY/FULL behave like the plain register; a beat accepted while the output is
  // stalled can only happen with the skid buffer and is parked there.
  always_comb begin
    w_state_nx = r_state;
    w_valid_nx = r_out_valid;
    w_ctrl_nx  = r_out_ctrl;
    w_data_nx  = r_out_data;
    w_skc_nx   = r_skid_ctrl;
    w_skd_nx   = r_skid_data;
    if (flush) begin
      w_state_nx = S_EMPTY;
      w_valid_nx = 1'b0;
      w_ctrl_nx  = '0;
      w_skc_nx   = '0;
    end else if (SKID == 0 || r_state != S_SKID) begin
      if (w_ld) begin
        w_state_nx = in_valid ? S_FULL : S_EMPTY;
        w_valid_nx = in_valid;
        w_ctrl_nx  = in_valid ? in_ctrl : '0;
        w_data_nx  = in_data;
      end else if (w_acc) begin
        w_state_nx = S_SKID;
        w_skc_nx   = in_ctrl;
        w_skd_nx   = in_data;
      end
    end else if (!stall) begin
      w_state_nx = S_FULL;
      w_valid_nx = 1'b1;
      w_ctrl_nx  = r_skid_ctrl;
      w_data_nx  = r_skid_data;
      w_skc_nx   = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_out_valid <= w_valid_nx;
      r_out_ctrl  <= w_ctrl_nx;
      r_out_data  <= w_data_nx;
      r_skid_ctrl <= w_skc_nx;
      r_skid_data <= w_skd_nx;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else if (stall && r_out_valid && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg (plain, skid and narrow-counter variants)
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;
  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [7:0]  oc0, oc1, oc2;
  logic [63:0] od0, od1, od2;
  logic [15:0] sc0, sc1;
  logic [1:0]  sc2;
  logic [71:0] sb[$];
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.SKID(0)) d0 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_ready(rdy0), .stall(stall), .flush(flush), .out_valid(ov0),
    .out_ctrl(oc0), .out_data(od0), .stall_cycles(sc0));
  pipe_stage_reg #(.SKID(1)) d1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_ready(rdy1), .stall(stall), .flush(flush), .out_valid(ov1),
    .out_ctrl(oc1), .out_data(od1), .stall_cycles(sc1));
  pipe_stage_reg #(.SKID(0), .CNT_W(2)) d2 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_ready(rdy2), .stall(stall), .flush(flush), .out_valid(ov2),
    .out_ctrl(oc2), .out_data(od2), .stall_cycles(sc2));
  // One clock: the skid DUT's departing beat is checked against the scoreboard, the
  // accepted beat is pushed, then we advance to the next falling edge.
  task automatic tick();
    logic [71:0] exp;
    if (ov1 && !stall && !flush) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_beat got=%h exp=none", {oc1, od1});
      end else begin
        exp = sb.pop_front();
        if ({oc1, od1} !== exp) begin
          errors++;
          $display("FAIL sb_beat got=%h exp=%h", {oc1, od1}, exp);
        end
      end
    end
    if (flush) sb.delete();
    else if (in_valid && rdy1) sb.push_back({in_ctrl, in_data});
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; in_ctrl = '0; in_data = '0;
    @(negedge clk);
    checks += 6;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", ov0); end
    if (oc0 !== 8'h0) begin errors++; $display("FAIL rst_ctrl got=%h exp=0", oc0); end
    if (od0 !== 64'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", od0); end
    if (sc0 !== 16'h0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", sc0); end
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL rst_ready_skid got=%b exp=1", rdy1); end
    if (ov1 !== 1'b0) begin errors++; $display("FAIL rst_valid_skid got=%b exp=0", ov1); end
    reset = 1'b0;
  endtask
  task automatic test_pass();
    in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 64'h1234;
    tick();
    checks += 3;
    if (ov0 !== 1'b1) begin errors++; $display("FAIL pass_valid got=%b exp=1", ov0); end
    if (oc0 !== 8'h5A) begin errors++; $display("FAIL pass_ctrl got=%h exp=5a", oc0); end
    if (od0 !== 64'h1234) begin errors++; $display("FAIL pass_data got=%h exp=1234", od0); end
    in_valid = 1'b0;
    tick();
    checks += 3;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL bubble_valid got=%b exp=0", ov0); end
    if (oc0 !== 8'h0) begin errors++; $display("FAIL bubble_ctrl got=%h exp=0", oc0); end
    if (od0 !== 64'h1234) begin errors++; $display("FAIL bubble_data got=%h exp=1234", od0); end
  endtask
  task automatic test_stall();
    in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 64'hAAAA;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_ctrl = 8'h10 + 8'(i); in_data = 64'(i);
      tick();
      checks += 4;
      if (ov0 !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", ov0); end
      if (oc0 !== 8'h5A) begin errors++; $display("FAIL stall_ctrl got=%h exp=5a", oc0); end
      if (od0 !== 64'hAAAA) begin errors++; $display("FAIL stall_data got=%h exp=aaaa", od0); end
      if (rdy0 !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", rdy0); end
    end
    checks++;
    if (sc0 !== 16'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", sc0); end
    stall = 1'b0; in_ctrl = 8'h77; in_data = 64'h77;
    tick();
    checks += 3;
    if (oc0 !== 8'h77) begin errors++; $display("FAIL release_ctrl got=%h exp=77", oc0); end
    if (od0 !== 64'h77) begin errors++; $display("FAIL release_data got=%h exp=77", od0); end
    if (sc0 !== 16'd3) begin errors++; $display("FAIL release_cnt got=%0d exp=3", sc0); end
    in_valid = 1'b0;
    tick();
    tick();
  endtask
  task automatic test_skid();
    in_valid = 1'b1; in_ctrl = 8'hA1; in_data = 64'hA;
    tick();
    checks++;
    if (oc1 !== 8'hA1) begin errors++; $display("FAIL skid_load_a got=%h exp=a1", oc1); end
    stall = 1'b1; in_ctrl = 8'hB2; in_data = 64'hB;
    tick();
    checks += 3;
    if (rdy1 !== 1'b0) begin errors++; $display("FAIL skid_ready got=%b exp=0", rdy1); end
    if (oc1 !== 8'hA1) begin errors++; $display("FAIL skid_hold_ctrl got=%h exp=a1", oc1); end
    if (od1 !== 64'hA) begin errors++; $display("FAIL skid_hold_data got=%h exp=a", od1); end
    in_valid = 1'b0;
    tick();
    checks++;
    if (oc1 !== 8'hA1) begin errors++; $display("FAIL skid_hold2 got=%h exp=a1", oc1); end
    stall = 1'b0;
    tick();
    checks += 3;
    if (oc1 !== 8'hB2) begin errors++; $display("FAIL skid_out_b got=%h exp=b2", oc1); end
    if (od1 !== 64'hB) begin errors++; $display("FAIL skid_out_b_data got=%h exp=b", od1); end
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL skid_ready_back got=%b exp=1", rdy1); end
    tick();
    checks += 2;
    if (ov1 !== 1'b0) begin errors++; $display("FAIL skid_drain got=%b exp=0", ov1); end
    if (sb.size() != 0) begin errors++; $display("FAIL skid_pending got=%0d exp=0", sb.size()); end
    tick();
    checks++;
    if (ov1 !== 1'b0) begin errors++; $display("FAIL skid_no_dup got=%b exp=0", ov1); end
  endtask
  task automatic test_flush();
    logic [15:0] sc;
    in_valid = 1'b1; in_ctrl = 8'hC3; in_data = 64'hC;
    tick();
    stall = 1'b1; in_ctrl = 8'hD4; in_data = 64'hD;
    tick();
    sc = sc1;
    flush = 1'b1; in_ctrl = 8'hE5; in_data = 64'hE;
    tick();
    checks += 5;
    if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", ov1); end
    if (oc1 !== 8'h0) begin errors++; $display("FAIL flush_ctrl got=%h exp=0", oc1); end
    if (od1 !== 64'hC) begin errors++; $display("FAIL flush_data_held got=%h exp=c", od1); end
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", rdy1); end
    if (sc1 !== sc + 16'd1) begin errors++; $display("FAIL flush_cnt got=%0d exp=%0d", sc1, sc + 16'd1); end
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    tick();
    checks += 2;
    if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_skid_empty got=%b exp=0", ov1); end
    if (sc1 !== sc + 16'd1) begin errors++; $display("FAIL flush_cnt_keep got=%0d exp=%0d", sc1, sc + 16'd1); end
  endtask
  task automatic test_saturate();
    reset = 1'b1; #1; reset = 1'b0;
    sb.delete();
    in_valid = 1'b1; in_ctrl = 8'h55; in_data = 64'h55;
    tick();
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks += 2;
      if (sc2 !== 2'((i < 3) ? i + 1 : 3)) begin errors++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, sc2, (i < 3) ? i + 1 : 3); end
      if (sc0 !== 16'(i + 1)) begin errors++; $display("FAIL wide_cnt%0d got=%0d exp=%0d", i, sc0, i + 1); end
    end
    stall = 1'b0;
    tick();
  endtask
  task automatic test_async_reset();
    in_valid = 1'b1; in_ctrl = 8'hF6; in_data = 64'hF;
    tick();
    stall = 1'b1; in_ctrl = 8'h07; in_data = 64'h7;
    tick();
    #2 reset = 1'b1;
    #1;
    checks += 5;
    if (ov1 !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", ov1); end
    if (oc1 !== 8'h0) begin errors++; $display("FAIL arst_ctrl got=%h exp=0", oc1); end
    if (od1 !== 64'h0) begin errors++; $display("FAIL arst_data got=%h exp=0", od1); end
    if (sc1 !== 16'h0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", sc1); end
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", rdy1); end
    sb.delete();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; stall = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_pass();
    test_stall();
    test_skid();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
